// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
//   dma_state_e : engine state (IDLE, START, XFER)
//   OAM_BASE    : first OAM byte written by a transfer
//   HRAM_LO/HI  : CPU window that stays reachable while a transfer runs
//   ECHO_MASK   : folds FExx/FFxx sources back onto DExx/DFxx
//   is_hram()   : HRAM address range test
package gb_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } dma_state_e;

   localparam logic [15:0] OAM_BASE      = 16'hFE00;
   localparam logic [15:0] HRAM_LO       = 16'hFF80;
   localparam logic [15:0] HRAM_HI       = 16'hFFFE;
   localparam logic [15:0] ECHO_MASK     = 16'hDFFF;
   localparam logic [7:0]  BLOCKED_RDATA = 8'hFF;

   function automatic logic is_hram(input logic [15:0] addr);
      return (addr >= HRAM_LO) && (addr <= HRAM_HI);
   endfunction

endpackage

// File: rtl/dma_bus_mux.sv
// Combinational selection between the CPU bus and the DMA path onto the memory port.
//   xfer               : transfer in progress (CPU locked out except HRAM window)
//   dma_rd / dma_wr    : DMA read (phase 0) / write (phase 1) cycle
//   dma_src / dma_dst  : DMA source and OAM destination addresses
//   dma_wdata          : byte latched during the read phase
//   dma_reg            : current DMA register value, returned on register reads
//   cpu_*              : CPU bus; cpu_rdata returns data (or BLOCKED_RDATA)
//   mem_*              : memory port
module dma_bus_mux
   import gb_dma_pkg::*;
#(
   parameter int unsigned     ADDR_WIDTH   = 16,
   parameter int unsigned     DATA_WIDTH   = 8,
   parameter logic [15:0]     DMA_REG_ADDR = 16'hFF46
) (
   input  logic                  xfer,
   input  logic                  dma_rd,
   input  logic                  dma_wr,
   input  logic [ADDR_WIDTH-1:0] dma_src,
   input  logic [ADDR_WIDTH-1:0] dma_dst,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   input  logic [DATA_WIDTH-1:0] dma_reg,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_wr_en,
   input  logic                  cpu_rd_en,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   logic reg_hit;
   logic cpu_fwd;

   always_comb begin
      reg_hit = (16'(cpu_addr) == DMA_REG_ADDR);
      // Outside a transfer the CPU owns the bus; inside, only HRAM in the window phases.
      cpu_fwd = !xfer || (!dma_rd && !dma_wr && is_hram(16'(cpu_addr)));

      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;

      if (dma_rd) begin
         mem_addr  = dma_src;
         mem_rd_en = 1'b1;
      end else if (dma_wr) begin
         mem_addr  = dma_dst;
         mem_wdata = dma_wdata;
         mem_wr_en = 1'b1;
      end else if (cpu_fwd) begin
         // The DMA register lives here, never in memory.
         mem_wr_en = cpu_wr_en && !reg_hit;
         mem_rd_en = cpu_rd_en;
      end

      if (reg_hit)      cpu_rdata = dma_reg;
      else if (cpu_fwd) cpu_rdata = mem_rdata;
      else              cpu_rdata = DATA_WIDTH'(BLOCKED_RDATA);
   end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA engine and CPU/DMA bus arbiter in front of the memory array.
// A CPU write to DMA_REG_ADDR copies BYTE_COUNT bytes from {dma_reg,8'h00} to FE00+.
// Optional feature macro: OAM_DMA_RESTART_EN -- a register write during a transfer
// restarts it with the new source; otherwise such writes are dropped.
//   clk, rst (async, active high)
//   cpu_addr/cpu_wdata/cpu_wr_en/cpu_rd_en in, cpu_rdata out
//   mem_addr/mem_wdata/mem_wr_en/mem_rd_en out, mem_rdata in (combinational read)
//   dma_active out : high from register write acceptance until last byte written
module oam_dma_controller
   import gb_dma_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter logic [15:0] DMA_REG_ADDR  = 16'hFF46,
   parameter int unsigned BYTE_COUNT    = 160,
   parameter int unsigned CLKS_PER_BYTE = 4,
   parameter int unsigned START_DELAY   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_wr_en,
   input  logic                  cpu_rd_en,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  dma_active
);

   localparam int unsigned PW  = $clog2(CLKS_PER_BYTE);
   localparam int unsigned DLW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   dma_state_e            state_q, state_d;
   logic [7:0]            dma_reg_q, dma_reg_d;
   logic [7:0]            idx_q, idx_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [DLW-1:0]        delay_q, delay_d;
   logic [DATA_WIDTH-1:0] latch_q, latch_d;

   logic                  trigger;
   logic [15:0]           src_full;
   logic [15:0]           dst_full;

   assign trigger    = cpu_wr_en && (16'(cpu_addr) == DMA_REG_ADDR);
   assign dma_active = (state_q != IDLE);

   always_comb begin
      src_full = {dma_reg_q, 8'h00} + {8'h00, idx_q};
      // Sources at E0xx and above would hit OAM/IO; fold them onto the echo of WRAM.
      if (dma_reg_q >= 8'hE0) src_full = src_full & ECHO_MASK;
      dst_full = OAM_BASE + {8'h00, idx_q};
   end

   always_comb begin
      state_d   = state_q;
      dma_reg_d = dma_reg_q;
      idx_d     = idx_q;
      phase_d   = phase_q;
      delay_d   = delay_q;
      latch_d   = latch_q;

      unique case (state_q)
         IDLE: begin
            if (trigger) begin
               dma_reg_d = cpu_wdata[7:0];
               idx_d     = '0;
               phase_d   = '0;
               delay_d   = '0;
               state_d   = START;
            end
         end
         START: begin
            if (delay_q == DLW'(START_DELAY - 1)) begin
               delay_d = '0;
               state_d = XFER;
            end else begin
               delay_d = delay_q + 1'b1;
            end
         end
         XFER: begin
            if (phase_q == '0) latch_d = mem_rdata;
            if (phase_q == PW'(CLKS_PER_BYTE - 1)) begin
               phase_d = '0;
               if (idx_q == 8'(BYTE_COUNT - 1)) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef OAM_DMA_RESTART_EN
      if (trigger && (state_q != IDLE)) begin
         dma_reg_d = cpu_wdata[7:0];
         idx_d     = '0;
         phase_d   = '0;
         delay_d   = '0;
         state_d   = START;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         dma_reg_q <= 8'h00;
         idx_q     <= '0;
         phase_q   <= '0;
         delay_q   <= '0;
         latch_q   <= '0;
      end else begin
         state_q   <= state_d;
         dma_reg_q <= dma_reg_d;
         idx_q     <= idx_d;
         phase_q   <= phase_d;
         delay_q   <= delay_d;
         latch_q   <= latch_d;
      end
   end

   dma_bus_mux #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .DMA_REG_ADDR(DMA_REG_ADDR)
   ) u_mux (
      .xfer     (state_q == XFER),
      .dma_rd   ((state_q == XFER) && (phase_q == '0)),
      .dma_wr   ((state_q == XFER) && (phase_q == PW'(1))),
      .dma_src  (ADDR_WIDTH'(src_full)),
      .dma_dst  (ADDR_WIDTH'(dst_full)),
      .dma_wdata(latch_q),
      .dma_reg  (DATA_WIDTH'(dma_reg_q)),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_wr_en(cpu_wr_en),
      .cpu_rd_en(cpu_rd_en),
      .cpu_rdata(cpu_rdata),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wr_en(mem_wr_en),
      .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata)
   );

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a 64 KiB memory model on the mem_* port.
module tb_oam_dma_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wr_en;
   logic        cpu_rd_en;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [7:0]  mem_rdata;
   logic        dma_active;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

   oam_dma_controller dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wr_en (cpu_wr_en),
      .cpu_rd_en (cpu_rd_en),
      .cpu_rdata (cpu_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .dma_active(dma_active)
   );

   // Returns at the negedge just after the accepting posedge.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_addr = a; cpu_wdata = d; cpu_wr_en = 1'b1; cpu_rd_en = 1'b0;
      @(negedge clk);
      cpu_wr_en = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      cpu_addr = a; cpu_rd_en = 1'b1; cpu_wr_en = 1'b0;
      #1 d = cpu_rdata;
      cpu_rd_en = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (dma_active && cycles < 3000) begin
         cycles++;
         @(negedge clk);
      end
      if (dma_active) begin
         vectors++; miscompares++;
         $display("FAIL wait_done: dma_active still %0b after %0d cycles, required 0", dma_active,
                  cycles);
      end
   endtask

   task automatic fill_oam(input logic [7:0] v);
      for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = v;
   endtask

   task automatic check_oam(input string name, input logic [15:0] src, input logic [7:0] key,
                            input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         vectors++;
         if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ key)) begin
            miscompares++;
            $display("FAIL %s: OAM[%0d] got %h, required %h (src %h)", name, i,
                     mem[16'hFE00 + 16'(i)], 8'(i) ^ key, src + 16'(i));
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'h00; cpu_wr_en = 1'b0; cpu_rd_en = 1'b1;
      mem[16'hC000] = 8'h42;
      #1;
      vectors++;
      if (dma_active !== 1'b0) begin
         miscompares++; $display("FAIL reset_active: got %b, required 0", dma_active);
      end
      vectors++;
      if (mem_addr !== 16'hC000 || mem_rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_passthru: addr %h rd %b, required C000 1", mem_addr, mem_rd_en);
      end
      vectors++;
      if (cpu_rdata !== 8'h42) begin
         miscompares++; $display("FAIL reset_rdata: got %h, required 42", cpu_rdata);
      end
      @(negedge clk); rst = 1'b0; cpu_rd_en = 1'b0;
      cpu_read(16'hFF46, d);
      vectors++;
      if (d !== 8'h00) begin
         miscompares++; $display("FAIL reset_dma_reg: got %h, required 00", d);
      end
   endtask

   task automatic test_basic_copy();
      int cyc;
      for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hFF46] = 8'h77;
      fill_oam(8'h00);
      @(negedge clk);
      cpu_addr = 16'hFF46; cpu_wdata = 8'hC0; cpu_wr_en = 1'b1;
      #1;
      vectors++;
      if (mem_wr_en !== 1'b0) begin
         miscompares++; $display("FAIL ff46_not_forwarded: mem_wr_en %b, required 0", mem_wr_en);
      end
      @(negedge clk);
      cpu_wr_en = 1'b0;
      wait_done(cyc);
      vectors++;
      if (cyc != 644) begin
         miscompares++; $display("FAIL active_time: got %0d clks, required 644", cyc);
      end
      check_oam("basic_copy", 16'hC000, 8'h5A, 0, 160);
      vectors++;
      if (mem[16'hFF46] !== 8'h77) begin
         miscompares++; $display("FAIL ff46_mem_untouched: got %h, required 77", mem[16'hFF46]);
      end
   endtask

   task automatic test_echo_fold();
      int cyc;
      for (int i = 0; i < 160; i++) begin
         mem[16'hDE00 + 16'(i)] = 8'(i) ^ 8'h33;
         mem[16'hFE00 + 16'(i)] = 8'hEE;
      end
      cpu_write(16'hFF46, 8'hFE);
      repeat (4) @(negedge clk);
      vectors++;
      if (mem_addr !== 16'hDE00 || mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL fold_phase0: addr %h rd %b wr %b, required DE00 1 0", mem_addr, mem_rd_en,
                  mem_wr_en);
      end
      @(negedge clk);
      vectors++;
      if (mem_addr !== 16'hFE00 || mem_wr_en !== 1'b1 || mem_wdata !== 8'h33) begin
         miscompares++;
         $display("FAIL fold_phase1: addr %h wr %b data %h, required FE00 1 33", mem_addr,
                  mem_wr_en, mem_wdata);
      end
      wait_done(cyc);
      check_oam("echo_fold", 16'hDE00, 8'h33, 0, 160);
   endtask

   task automatic test_cpu_lockout();
      int cyc;
      logic [7:0] d;
      mem[16'hC123] = 8'h77;
      mem[16'hC010] = 8'h11;
      mem[16'hFF90] = 8'h00;
      cpu_write(16'hFF46, 8'hC0);
      repeat (10) @(negedge clk);
      cpu_read(16'hC123, d);
      vectors++;
      if (d !== 8'hFF) begin
         miscompares++; $display("FAIL blocked_read: got %h, required FF", d);
      end
      // Hold each write for a full byte period so it overlaps a CPU window.
      @(negedge clk);
      cpu_addr = 16'hFF90; cpu_wdata = 8'h3C; cpu_wr_en = 1'b1;
      repeat (4) @(negedge clk);
      cpu_addr = 16'hC010; cpu_wdata = 8'hAA;
      repeat (4) @(negedge clk);
      cpu_wr_en = 1'b0;
      cpu_read(16'hFF46, d);
      vectors++;
      if (d !== 8'hC0) begin
         miscompares++; $display("FAIL ff46_readback: got %h, required C0", d);
      end
      wait_done(cyc);
      cpu_read(16'hFF90, d);
      vectors++;
      if (d !== 8'h3C) begin
         miscompares++; $display("FAIL hram_window_write: got %h, required 3C", d);
      end
      cpu_read(16'hC010, d);
      vectors++;
      if (d !== 8'h11) begin
         miscompares++; $display("FAIL blocked_write: got %h, required 11", d);
      end
      cpu_read(16'hC123, d);
      vectors++;
      if (d !== 8'h77) begin
         miscompares++; $display("FAIL passthru_after: got %h, required 77", d);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d;
      for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      fill_oam(8'hEE);
      cpu_write(16'hFF46, 8'hC0);
      // First START cycle now; byte 80 read phase is 324 cycles later.
      repeat (324) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (dma_active !== 1'b0) begin
         miscompares++; $display("FAIL abort_active: got %b, required 0", dma_active);
      end
      rst = 1'b0;
      check_oam("abort_written", 16'hC000, 8'h5A, 0, 80);
      for (int i = 80; i < 160; i++) begin
         vectors++;
         if (mem[16'hFE00 + 16'(i)] !== 8'hEE) begin
            miscompares++;
            $display("FAIL abort_untouched: OAM[%0d] got %h, required EE", i,
                     mem[16'hFE00 + 16'(i)]);
         end
      end
      cpu_read(16'hC005, d);
      vectors++;
      if (d !== (8'h05 ^ 8'h5A)) begin
         miscompares++; $display("FAIL abort_passthru: got %h, required %h", d, 8'h05 ^ 8'h5A);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [7:0] d;
      for (int i = 0; i < 160; i++) begin
         mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
         mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
      end
      fill_oam(8'h00);
      cpu_write(16'hFF46, 8'hC0);
      repeat (164) @(negedge clk);
      cpu_write(16'hFF46, 8'hD0);
      wait_done(cyc);
      cpu_read(16'hFF46, d);
`ifdef OAM_DMA_RESTART_EN
      check_oam("restart_copy", 16'hD000, 8'hA5, 0, 160);
      vectors++;
      if (d !== 8'hD0) begin
         miscompares++; $display("FAIL restart_reg: got %h, required D0", d);
      end
`else
      check_oam("ignore_copy", 16'hC000, 8'h5A, 0, 160);
      vectors++;
      if (d !== 8'hC0) begin
         miscompares++; $display("FAIL ignore_reg: got %h, required C0", d);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_basic_copy();
      test_echo_fold();
      test_cpu_lockout();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
